tile_map_writer: RTL

//  Owns the 20x15 playfield tile map that color_mapper paints from. It loads a level from an

---
 rtl/tile_map_writer_pkg.sv | 42 ++++
 rtl/tile_map_writer_if.sv | 24 ++
 rtl/tile_map_writer_coord_check.sv | 22 ++
 rtl/tile_map_writer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tile_map_writer_pkg.sv
// tank_map_pkg: tile and edit-op encodings, playfield geometry and index helpers
// shared by the tile map writer and its coordinate checker.
// Build option: define MAP_BORDER_EN to pin the outer ring of tiles to WALL.
package tank_map_pkg;

    localparam int MAP_W     = 20;
    localparam int MAP_H     = 15;
    localparam int MAP_TILES = MAP_W * MAP_H;
    localparam int TILE_BITS = 2;
    localparam int X_BITS    = 5;
    localparam int Y_BITS    = 4;
    localparam int IDX_BITS  = 9;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(MAP_TILES - 1);
    localparam logic [IDX_BITS-1:0] GOLD_MAX = IDX_BITS'(MAP_TILES);

`ifdef MAP_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {EMPTY, WALL, BRICK, GOLD} tile_t;
    typedef enum logic [1:0] {SET, CLEAR, HIT, NOP} map_op_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} load_state_t;

    // Row-major tile index used by the ROM, map_flat and both coordinate ports.
    function automatic logic [IDX_BITS-1:0] tile_idx(input logic [X_BITS-1:0] x,
                                                     input logic [Y_BITS-1:0] y);
        return IDX_BITS'(int'(y) * MAP_W + int'(x));
    endfunction

    // Border test on a linear index, needed while streaming ROM data by address.
    function automatic logic idx_on_border(input logic [IDX_BITS-1:0] idx);
        int i;
        int col;
        i   = int'(idx);
        col = i % MAP_W;
        return (i < MAP_W) || (i >= MAP_TILES - MAP_W) || (col == 0) || (col == MAP_W - 1);
    endfunction

endpackage

// File: rtl/tile_map_writer_if.sv
// Tile edit channel between game logic (master) and the tile map writer (slave).
// Valid/ready handshake plus a one-cycle error pulse for out-of-range edits.
interface tile_map_writer_if;
    import tank_map_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [X_BITS-1:0] wr_x;
    logic [Y_BITS-1:0] wr_y;
    map_op_t           wr_op;
    tile_t             wr_tile;
    logic              wr_err;

    modport master (
        output wr_valid, wr_x, wr_y, wr_op, wr_tile,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_op, wr_tile,
        output wr_ready, wr_err
    );

endinterface

// File: rtl/tile_map_writer_coord_check.sv
// map_coord_check: combinational range check, linear index and border flag for a
// tile coordinate. The border flag is only ever raised in border-enabled builds.
module map_coord_check
    import tank_map_pkg::*;
(
    input  logic [X_BITS-1:0]   x,
    input  logic [Y_BITS-1:0]   y,
    output logic                in_range,
    output logic [IDX_BITS-1:0] idx,
    output logic                is_border
);

    // Everything here is a pure function of the coordinate.
    always_comb begin
        in_range  = (int'(x) < MAP_W) && (int'(y) < MAP_H);
        idx       = tile_idx(x, y);
        is_border = BORDER_EN && in_range &&
                    ((x == '0) || (int'(x) == MAP_W - 1) ||
                     (y == '0) || (int'(y) == MAP_H - 1));
    end

endmodule

// File: rtl/tile_map_writer.sv
// tile_map_writer: owns the 20x15 playfield tile map. Loads a level from a
// synchronous tile ROM, then applies SET/CLEAR/HIT edits over a valid/ready
// channel while idle. Exports the flattened map, a registered point read and a
// live count of GOLD tiles.
// Build option: MAP_BORDER_EN (see tank_map_pkg) forces border tiles to WALL.
module tile_map_writer
    import tank_map_pkg::*;
(
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            load_start,
    output logic [IDX_BITS-1:0]             rom_addr,
    input  logic [TILE_BITS-1:0]            rom_data,
    tile_map_writer_if.slave                wr,
    input  logic [X_BITS-1:0]               rd_x,
    input  logic [Y_BITS-1:0]               rd_y,
    output logic [TILE_BITS-1:0]            rd_tile,
    output logic [MAP_TILES*TILE_BITS-1:0]  map_flat,
    output logic [IDX_BITS-1:0]             gold_count,
    output logic                            busy,
    output logic                            load_done
);

    load_state_t                    state_q, state_d;
    logic [MAP_TILES*TILE_BITS-1:0] map_q;

    logic                edit_in_range, edit_border;
    logic [IDX_BITS-1:0] edit_idx;
    logic                rd_in_range, rd_border;
    logic [IDX_BITS-1:0] rd_idx;

    logic                edit_accept, edit_apply;
    tile_t               edit_old, edit_new;
    logic                load_we, load_wr;
    logic [IDX_BITS-1:0] load_idx;

    map_coord_check u_edit_coord (
        .x         (wr.wr_x),
        .y         (wr.wr_y),
        .in_range  (edit_in_range),
        .idx       (edit_idx),
        .is_border (edit_border)
    );

    map_coord_check u_rd_coord (
        .x         (rd_x),
        .y         (rd_y),
        .in_range  (rd_in_range),
        .idx       (rd_idx),
        .is_border (rd_border)
    );

    // Load sequencer state register; reset abandons any partial load.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and status; a load request blocks the edit handshake in the same cycle.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        load_done   = 1'b0;
        wr.wr_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr.wr_ready = !load_start;
                if (load_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (rom_addr == LAST_IDX) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                load_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ROM data lags the address by a cycle, so each write targets the previous address.
    always_comb begin
        load_we  = ((state_q == S_LOAD) && (rom_addr != '0)) || (state_q == S_FLUSH);
        load_idx = (state_q == S_FLUSH) ? rom_addr : rom_addr - 1'b1;
        load_wr  = load_we && !(BORDER_EN && idx_on_border(load_idx));
    end

    // Edit decode: resulting tile for the addressed cell, and whether it lands.
    always_comb begin
        edit_accept = wr.wr_valid && wr.wr_ready;
        edit_apply  = edit_accept && edit_in_range && !edit_border;
        edit_old    = tile_t'(map_q[{edit_idx, 1'b0} +: TILE_BITS]);
        edit_new    = edit_old;
        case (wr.wr_op)
            SET:     edit_new = wr.wr_tile;
            CLEAR:   edit_new = EMPTY;
            HIT:     edit_new = ((edit_old == BRICK) || (edit_old == GOLD)) ? EMPTY : edit_old;
            default: edit_new = edit_old;
        endcase
    end

    // ROM address walks 0..299 during LOAD and restarts on every new load.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            rom_addr <= '0;
        else if ((state_q == S_IDLE) && load_start)
            rom_addr <= '0;
        else if ((state_q == S_LOAD) && (rom_addr != LAST_IDX))
            rom_addr <= rom_addr + 1'b1;
    end

    // Tile storage, written by the loader or by an accepted in-range edit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            map_q <= '0;
        else if (load_wr)
            map_q[{load_idx, 1'b0} +: TILE_BITS] <= rom_data;
        else if (edit_apply)
            map_q[{edit_idx, 1'b0} +: TILE_BITS] <= edit_new;
    end

    // Gold tally tracks every write into or out of GOLD and saturates at both ends.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gold_count <= '0;
        end else if ((state_q == S_IDLE) && load_start) begin
            gold_count <= '0;
        end else if (load_wr) begin
            if ((rom_data == GOLD) && (gold_count != GOLD_MAX))
                gold_count <= gold_count + 1'b1;
        end else if (edit_apply) begin
            if ((edit_old == GOLD) && (edit_new != GOLD) && (gold_count != '0))
                gold_count <= gold_count - 1'b1;
            else if ((edit_old != GOLD) && (edit_new == GOLD) && (gold_count != GOLD_MAX))
                gold_count <= gold_count + 1'b1;
        end
    end

    // Out-of-range edits still complete the handshake but flag an error next cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) wr.wr_err <= 1'b0;
        else          wr.wr_err <= edit_accept && !edit_in_range;
    end

    // Registered point read; border tiles read WALL, off-map coordinates read EMPTY.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            rd_tile <= '0;
        else if (!rd_in_range)
            rd_tile <= EMPTY;
        else if (rd_border)
            rd_tile <= WALL;
        else
            rd_tile <= map_q[{rd_idx, 1'b0} +: TILE_BITS];
    end

    for (genvar i = 0; i < MAP_TILES; i++) begin : g_flat
        if (BORDER_EN && ((i < MAP_W) || (i >= MAP_TILES - MAP_W) ||
                          (i % MAP_W == 0) || (i % MAP_W == MAP_W - 1))) begin : g_wall
            assign map_flat[TILE_BITS*i +: TILE_BITS] = WALL;
        end else begin : g_tile
            assign map_flat[TILE_BITS*i +: TILE_BITS] = map_q[TILE_BITS*i +: TILE_BITS];
        end
    end

endmodule
